alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage.sv | 154 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Decode-to-execute operand stage: resolves EX/WB forwarding, builds immediates,
// selects ALU operands by opcode and holds one entry behind a ready/valid handshake.
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [11:0]      imm12,
  input  logic [19:0]      u_imm20,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             ex_we,
  input  logic [4:0]       ex_rd,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  data0,
  output logic [XLEN-1:0]  data1,
  output logic             alu_en,
  output logic [2:0]       funct3_q,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic             out_valid_reg;
  logic [XLEN-1:0]  data0_reg, data1_reg;
  logic             alu_en_reg;
  logic [2:0]       funct3_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic [XLEN-1:0]  data0_next, data1_next;
  logic             alu_en_next;
  logic             capture;

  logic [1:0][4:0]      rs_idx;
  logic [1:0][XLEN-1:0] rf_rd;
  logic [31:0]          u_word;
  logic [XLEN-1:0]      imm_sx, uimm_sx, shamt_zx;

  assign rs_idx = {rs2, rs1};
  assign rf_rd  = {rs2_data, rs1_data};

  // Reset forces ready so the upstream never stalls on a stage being cleared.
  assign in_ready = reset | ~out_valid_reg | out_ready;
  assign capture  = in_valid & in_ready & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [XLEN-1:0] val;
      always_comb begin
        val = rf_rd[gi];
        if (rs_idx[gi] == 5'd0)
          val = '0;
        else if (FWD_EN != 0 && ex_we && ex_rd == rs_idx[gi])
          val = ex_data;
        else if (FWD_EN != 0 && wb_we && wb_rd == rs_idx[gi])
          val = wb_data;
      end
    end
  endgenerate

  assign u_word   = {u_imm20, 12'b0};
  assign imm_sx   = XLEN'($signed(imm12));
  assign uimm_sx  = XLEN'($signed(u_word));
  assign shamt_zx = XLEN'(imm12[SHW-1:0]);

  always_comb begin
    data0_next  = '0;
    data1_next  = '0;
    alu_en_next = 1'b1;
    case (opcode)
      OPC_OP, OPC_BRANCH: begin
        data0_next = g_fwd[0].val;
        data1_next = g_fwd[1].val;
      end
      OPC_OP_IMM: begin
        data0_next = g_fwd[0].val;
        data1_next = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt_zx : imm_sx;
      end
      OPC_LOAD, OPC_STORE: begin
        data0_next = g_fwd[0].val;
        data1_next = imm_sx;
      end
      OPC_LUI: data1_next = uimm_sx;
      OPC_AUIPC: begin
        data0_next = pc;
        data1_next = uimm_sx;
      end
      OPC_JAL, OPC_JALR: begin
        data0_next = pc;
        data1_next = XLEN'(4);
      end
      default: alu_en_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      data0_reg     <= '0;
      data1_reg     <= '0;
      alu_en_reg    <= 1'b0;
      funct3_reg    <= 3'b0;
      stall_cnt_reg <= '0;
    end else begin
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (capture) begin
        out_valid_reg <= 1'b1;
        data0_reg     <= data0_next;
        data1_reg     <= data1_next;
        alu_en_reg    <= alu_en_next;
        funct3_reg    <= funct3;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (out_valid_reg && !out_ready && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_reg;
  assign data0     = data0_reg;
  assign data1     = data1_reg;
  assign alu_en    = alu_en_reg;
  assign funct3_q  = funct3_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench: a 32-bit/16-bit-counter instance and a 64-bit/2-bit-counter
// instance share stimulus; expected values are hand-computed constants.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, ex_rd, wb_rd;
  logic [11:0] imm12;
  logic [19:0] u_imm20;
  logic [63:0] pc, rs1_data, rs2_data, ex_data, wb_data;
  logic        ex_we, wb_we;

  logic        a_in_ready, a_out_valid, a_alu_en;
  logic [31:0] a_data0, a_data1;
  logic [2:0]  a_funct3_q;
  logic [15:0] a_stall_cnt;

  logic        b_in_ready, b_out_valid, b_alu_en;
  logic [63:0] b_data0, b_data1;
  logic [2:0]  b_funct3_q;
  logic [1:0]  b_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .FWD_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .opcode(opcode), .funct3(funct3), .rs1(rs1), .rs2(rs2), .imm12(imm12),
    .u_imm20(u_imm20), .pc(pc[31:0]), .rs1_data(rs1_data[31:0]), .rs2_data(rs2_data[31:0]),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data[31:0]),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data[31:0]),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .data0(a_data0), .data1(a_data1), .alu_en(a_alu_en), .funct3_q(a_funct3_q),
    .stall_cnt(a_stall_cnt)
  );

  alu_operand_stage #(.XLEN(64), .FWD_EN(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .opcode(opcode), .funct3(funct3), .rs1(rs1), .rs2(rs2), .imm12(imm12),
    .u_imm20(u_imm20), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .data0(b_data0), .data1(b_data1), .alu_en(b_alu_en), .funct3_q(b_funct3_q),
    .stall_cnt(b_stall_cnt)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2;
    logic [11:0] imm;
    logic [19:0] uimm;
    logic [31:0] pc, r1, r2;
    logic        exwe;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [31:0] e0, e1;
    logic        een;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; flush = 0; out_ready = 1;
    opcode = '0; funct3 = '0; rs1 = '0; rs2 = '0; imm12 = '0; u_imm20 = '0;
    pc = '0; rs1_data = '0; rs2_data = '0;
    ex_we = 0; ex_rd = '0; ex_data = '0; wb_we = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid = 1;
    opcode = v.op; funct3 = v.f3; rs1 = v.rs1; rs2 = v.rs2; imm12 = v.imm; u_imm20 = v.uimm;
    pc = {32'h0, v.pc}; rs1_data = {32'h0, v.r1}; rs2_data = {32'h0, v.r2};
    ex_we = v.exwe; ex_rd = v.exrd; ex_data = {32'h0, v.exd};
    wb_we = v.wbwe; wb_rd = v.wbrd; wb_data = {32'h0, v.wbd};
  endtask

  task automatic addi(input logic [11:0] imm);
    in_valid = 1; opcode = 7'b0010011; funct3 = 3'b000; rs1 = 5'd0; imm12 = imm;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          op          f3    rs1   rs2   imm      uimm     pc        r1        r2        exwe exrd  exd      wbwe wbrd  wbd      e0        e1            en
    vecs[0]  = '{7'b0010011, 3'd0, 5'd1, 5'd0, 12'hFFF, 20'h0,   32'h0,    32'h10,   32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h10,   32'hFFFFFFFF, 1'b1};
    vecs[1]  = '{7'b0110011, 3'd0, 5'd5, 5'd6, 12'h0,   20'h0,   32'h0,    32'h11,   32'h22,   1'b1, 5'd5, 32'hAA,  1'b1, 5'd5, 32'hBB,  32'hAA,   32'h22,       1'b1};
    vecs[2]  = '{7'b0110011, 3'd0, 5'd0, 5'd6, 12'h0,   20'h0,   32'h0,    32'h11,   32'h22,   1'b1, 5'd0, 32'hAA,  1'b1, 5'd0, 32'hBB,  32'h0,    32'h22,       1'b1};
    vecs[3]  = '{7'b0110011, 3'd0, 5'd3, 5'd7, 12'h0,   20'h0,   32'h0,    32'h33,   32'h77,   1'b1, 5'd4, 32'hAA,  1'b1, 5'd7, 32'hBB,  32'h33,   32'hBB,       1'b1};
    vecs[4]  = '{7'b1100011, 3'd1, 5'd9, 5'd9, 12'h0,   20'h0,   32'h0,    32'h99,   32'h99,   1'b0, 5'd9, 32'hAA,  1'b0, 5'd9, 32'hBB,  32'h99,   32'h99,       1'b1};
    vecs[5]  = '{7'b0010011, 3'd1, 5'd2, 5'd0, 12'h43F, 20'h0,   32'h0,    32'h5,    32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h5,    32'h1F,       1'b1};
    vecs[6]  = '{7'b0010011, 3'd5, 5'd2, 5'd0, 12'h405, 20'h0,   32'h0,    32'h5,    32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h5,    32'h5,        1'b1};
    vecs[7]  = '{7'b0000011, 3'd2, 5'd1, 5'd0, 12'h800, 20'h0,   32'h0,    32'h1000, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h1000, 32'hFFFFF800, 1'b1};
    vecs[8]  = '{7'b0100011, 3'd2, 5'd1, 5'd2, 12'h7FF, 20'h0,   32'h0,    32'h20,   32'h30,   1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h20,   32'h7FF,      1'b1};
    vecs[9]  = '{7'b0110111, 3'd0, 5'd1, 5'd0, 12'h0,   20'h12345, 32'h0,  32'h55,   32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h0,    32'h12345000, 1'b1};
    vecs[10] = '{7'b0010111, 3'd0, 5'd0, 5'd0, 12'h0,   20'h80000, 32'h1000, 32'h0,  32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h1000, 32'h80000000, 1'b1};
    vecs[11] = '{7'b1101111, 3'd0, 5'd0, 5'd0, 12'h0,   20'h0,   32'h2000, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h2000, 32'h4,        1'b1};
    vecs[12] = '{7'b1100111, 3'd0, 5'd1, 5'd0, 12'h0,   20'h0,   32'h3004, 32'h9,    32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h3004, 32'h4,        1'b1};
    vecs[13] = '{7'b1111111, 3'd0, 5'd1, 5'd0, 12'h0,   20'h0,   32'h0,    32'h44,   32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h0,    32'h0,        1'b0};
    vecs[14] = '{7'b0010011, 3'd7, 5'd1, 5'd0, 12'h0F0, 20'h0,   32'h0,    32'h7,    32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h7,    32'hF0,       1'b1};

    // Reset with an instruction offered and downstream not ready
    clear_inputs();
    reset = 1; out_ready = 0;
    drive_vec(vecs[0]);
    #1;
    chk("in_ready_in_reset", {63'h0, a_in_ready}, 64'h1);
    step(); step();
    chk("reset_out_valid", {63'h0, a_out_valid}, 64'h0);
    chk("reset_data0", {32'h0, a_data0}, 64'h0);
    chk("reset_data1", {32'h0, a_data1}, 64'h0);
    chk("reset_alu_en", {63'h0, a_alu_en}, 64'h0);
    chk("reset_funct3_q", {61'h0, a_funct3_q}, 64'h0);
    chk("reset_stall_cnt", {48'h0, a_stall_cnt}, 64'h0);
    chk("reset_in_ready", {63'h0, a_in_ready}, 64'h1);
    reset = 0;
    clear_inputs();

    // Back-to-back operand selection vectors
    for (int i = 0; i < 15; i++) begin
      drive_vec(vecs[i]);
      step();
      $display("vec %0d: op=%b data0=0x%0h data1=0x%0h alu_en=%0d", i, vecs[i].op, a_data0, a_data1, a_alu_en);
      chk($sformatf("vec%0d_out_valid", i), {63'h0, a_out_valid}, 64'h1);
      chk($sformatf("vec%0d_data0", i), {32'h0, a_data0}, {32'h0, vecs[i].e0});
      chk($sformatf("vec%0d_data1", i), {32'h0, a_data1}, {32'h0, vecs[i].e1});
      chk($sformatf("vec%0d_alu_en", i), {63'h0, a_alu_en}, {63'h0, vecs[i].een});
      chk($sformatf("vec%0d_funct3_q", i), {61'h0, a_funct3_q}, {61'h0, vecs[i].f3});
    end

    // Stall: entry held for 5 cycles, new EX result for rs1 must not leak in
    clear_inputs();
    drive_vec(vecs[0]);
    step();
    out_ready = 0;
    opcode = 7'b0110111; u_imm20 = 20'hABCDE;
    ex_we = 1; ex_rd = 5'd1; ex_data = 64'hDEAD;
    #1;
    chk("stall_in_ready", {63'h0, a_in_ready}, 64'h0);
    for (int c = 0; c < 5; c++) begin
      step();
      $display("stall cycle %0d: data0=0x%0h data1=0x%0h cnt=%0d", c, a_data0, a_data1, a_stall_cnt);
      chk("stall_out_valid", {63'h0, a_out_valid}, 64'h1);
      chk("stall_data0", {32'h0, a_data0}, 64'h10);
      chk("stall_data1", {32'h0, a_data1}, 64'hFFFFFFFF);
      chk("stall_alu_en", {63'h0, a_alu_en}, 64'h1);
    end
    chk("stall_cnt_16b", {48'h0, a_stall_cnt}, 64'd5);
    chk("stall_cnt_2b_sat", {62'h0, b_stall_cnt}, 64'd3);

    // Flush with entry held and a new instruction offered
    flush = 1;
    step();
    $display("flush: out_valid=%0d", a_out_valid);
    chk("flush_out_valid", {63'h0, a_out_valid}, 64'h0);
    flush = 0; in_valid = 0; out_ready = 1;
    step();
    chk("flush_dropped", {63'h0, a_out_valid}, 64'h0);

    // Four back-to-back instructions at full rate, then drain
    clear_inputs();
    for (int k = 1; k <= 4; k++) begin
      addi(12'(k));
      step();
      $display("b2b %0d: out_valid=%0d data1=0x%0h", k, a_out_valid, a_data1);
      chk("b2b_out_valid", {63'h0, a_out_valid}, 64'h1);
      chk("b2b_data1", {32'h0, a_data1}, 64'(k));
    end
    in_valid = 0;
    step();
    chk("drain_out_valid", {63'h0, a_out_valid}, 64'h0);

    // Reset pulse in the second cycle of a stream
    addi(12'd1);
    step();
    chk("rst_seq_first", {32'h0, a_data1}, 64'h1);
    addi(12'd2);
    reset = 1; out_ready = 0;
    #1;
    chk("rst_seq_in_ready", {63'h0, a_in_ready}, 64'h1);
    step();
    reset = 0; in_valid = 0; out_ready = 1;
    $display("reset pulse: out_valid=%0d stall_cnt=%0d", a_out_valid, a_stall_cnt);
    chk("rst_seq_out_valid", {63'h0, a_out_valid}, 64'h0);
    chk("rst_seq_stall_cnt", {48'h0, a_stall_cnt}, 64'h0);
    chk("rst_seq_data1", {32'h0, a_data1}, 64'h0);
    step();
    chk("rst_seq_no_replay", {63'h0, a_out_valid}, 64'h0);

    // 64-bit datapath corner cases
    clear_inputs();
    in_valid = 1; opcode = 7'b0010011; funct3 = 3'b001; rs1 = 5'd0; imm12 = 12'h03F;
    step();
    $display("x64 slli: data1=0x%0h", b_data1);
    chk("x64_slli_data1", b_data1, 64'd63);
    chk("x32_slli_data1", {32'h0, a_data1}, 64'h1F);
    opcode = 7'b0110111; funct3 = 3'b000; u_imm20 = 20'h80000;
    step();
    $display("x64 lui: data1=0x%0h", b_data1);
    chk("x64_lui_data1", b_data1, 64'hFFFFFFFF80000000);
    chk("x32_lui_data1", {32'h0, a_data1}, 64'h80000000);
    opcode = 7'b0010111; u_imm20 = 20'h00001; pc = 64'h1000;
    step();
    $display("x64 auipc: data0=0x%0h data1=0x%0h", b_data0, b_data1);
    chk("x64_auipc_data0", b_data0, 64'h1000);
    chk("x64_auipc_data1", b_data1, 64'h1000);
    in_valid = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
